// File: rtl/requant_pipe.sv
// Four-stage multi-lane requantizer: SRDHM, rounding shift, offset add, activation clamp.
// All stages advance together under a single valid/ready handshake with full backpressure.
module requant_pipe #(
  parameter int LANES = 4,
  parameter int OUT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [32*LANES-1:0]    in_acc,
  input  logic [31:0]            mult,
  input  logic [4:0]             shift,
  input  logic [31:0]            out_offset,
  input  logic [31:0]            act_min,
  input  logic [31:0]            act_max,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W*LANES-1:0] out_data
);

  localparam logic signed [32:0] QMAX = (33'sd1 <<< (OUT_W - 1)) - 33'sd1;
  localparam logic signed [32:0] QMIN = -(33'sd1 <<< (OUT_W - 1));

  logic               advance;
  logic               s1_valid_reg, s2_valid_reg, s3_valid_reg, s4_valid_reg;
  logic [4:0]         s1_shift_reg, s2_shift_reg;
  logic [31:0]        s1_off_reg, s2_off_reg, s3_off_reg;
  logic [31:0]        s1_min_reg, s2_min_reg, s3_min_reg;
  logic [31:0]        s1_max_reg, s2_max_reg, s3_max_reg;
  logic signed [63:0] mult64;

  assign advance   = !s4_valid_reg || out_ready;
  assign in_ready  = advance;
  assign out_valid = s4_valid_reg;
  assign mult64    = {{32{mult[31]}}, mult};

  // Flush takes priority over both stall and a simultaneous accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      s3_valid_reg <= 1'b0;
      s4_valid_reg <= 1'b0;
    end else if (flush) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      s3_valid_reg <= 1'b0;
      s4_valid_reg <= 1'b0;
    end else if (advance) begin
      s1_valid_reg <= in_valid;
      s2_valid_reg <= s1_valid_reg;
      s3_valid_reg <= s2_valid_reg;
      s4_valid_reg <= s3_valid_reg;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_shift_reg <= '0;
      s2_shift_reg <= '0;
      s1_off_reg   <= '0;
      s2_off_reg   <= '0;
      s3_off_reg   <= '0;
      s1_min_reg   <= '0;
      s2_min_reg   <= '0;
      s3_min_reg   <= '0;
      s1_max_reg   <= '0;
      s2_max_reg   <= '0;
      s3_max_reg   <= '0;
    end else if (advance) begin
      s1_shift_reg <= shift;
      s2_shift_reg <= s1_shift_reg;
      s1_off_reg   <= out_offset;
      s2_off_reg   <= s1_off_reg;
      s3_off_reg   <= s2_off_reg;
      s1_min_reg   <= act_min;
      s2_min_reg   <= s1_min_reg;
      s3_min_reg   <= s2_min_reg;
      s1_max_reg   <= act_max;
      s2_max_reg   <= s1_max_reg;
      s3_max_reg   <= s2_max_reg;
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [63:0]    acc64, p_next, p_reg;
    logic                  sat_next, sat_reg;
    logic signed [63:0]    nudge, sum, biased;
    logic signed [31:0]    h_next, h_reg;
    logic [31:0]           mask, rem, thr;
    logic signed [31:0]    h_sh, r_next, r_reg;
    logic signed [32:0]    s_sum, s_lo, s_hi, s_act, s_out;
    logic [OUT_W-1:0]      y_next, y_reg;

    always_comb begin
      acc64    = {{32{in_acc[32*gi+31]}}, in_acc[32*gi +: 32]};
      p_next   = acc64 * mult64;
      sat_next = (in_acc[32*gi +: 32] == 32'h8000_0000) && (mult == 32'h8000_0000);
    end

    // Bias negative sums by 2^31-1 so the arithmetic shift truncates toward zero.
    always_comb begin
      nudge  = p_reg[63] ? 64'shFFFF_FFFF_C000_0001 : 64'sh0000_0000_4000_0000;
      sum    = p_reg + nudge;
      biased = sum[63] ? (sum + 64'sh0000_0000_7FFF_FFFF) : sum;
      h_next = sat_reg ? 32'sh7FFF_FFFF : 32'(biased >>> 31);
    end

    always_comb begin
      mask   = (32'd1 << s2_shift_reg) - 32'd1;
      rem    = h_reg & mask;
      thr    = (mask >> 1) + {31'd0, h_reg[31]};
      h_sh   = h_reg >>> s2_shift_reg;
      r_next = h_sh + ((rem > thr) ? 32'sd1 : 32'sd0);
    end

    always_comb begin
      s_sum  = {r_reg[31], r_reg} + {s3_off_reg[31], s3_off_reg};
      s_lo   = {s3_min_reg[31], s3_min_reg};
      s_hi   = {s3_max_reg[31], s3_max_reg};
      s_act  = (s_sum < s_lo) ? s_lo : ((s_sum > s_hi) ? s_hi : s_sum);
      s_out  = (s_act < QMIN) ? QMIN : ((s_act > QMAX) ? QMAX : s_act);
      y_next = OUT_W'(s_out);
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        p_reg   <= '0;
        sat_reg <= 1'b0;
        h_reg   <= '0;
        r_reg   <= '0;
        y_reg   <= '0;
      end else if (advance) begin
        p_reg   <= p_next;
        sat_reg <= sat_next;
        h_reg   <= h_next;
        r_reg   <= r_next;
        y_reg   <= y_next;
      end
    end

    assign out_data[OUT_W*gi +: OUT_W] = y_reg;
  end

endmodule

// File: tb/tb_requant_pipe.sv
// Randomized and directed bench for requant_pipe against an arithmetic reference model.
module tb_requant_pipe;
  localparam int LANES = 4;
  localparam int OUT_W = 8;
  localparam int VW = LANES * OUT_W;

  logic clk = 1'b0, reset_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [32*LANES-1:0] in_acc = '0;
  logic [31:0] mult = '0, out_offset = '0, act_min = '0, act_max = '0;
  logic [4:0] shift = '0;
  logic [VW-1:0] out_data;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [32*LANES-1:0] acc;
    logic [31:0] mult;
    logic [4:0]  shift;
    logic [31:0] off, mn, mx;
  } beat_t;

  logic [VW-1:0] exp_q[$];

  always #5 clk = ~clk;

  requant_pipe #(.LANES(LANES), .OUT_W(OUT_W)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_acc(in_acc), .mult(mult), .shift(shift), .out_offset(out_offset),
    .act_min(act_min), .act_max(act_max), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: exact rounding divide, round-half-away-from-zero shift, then clamps.
  function automatic logic [OUT_W-1:0] ref_lane(int acc, int m, int sh, int off, int mn, int mx);
    longint two30, two31, p, h, r, s, d, a, q, lo, hi;
    logic [OUT_W-1:0] res;
    two30 = 64'sd1073741824;
    two31 = 64'sd2147483648;
    if (acc == 32'sh8000_0000 && m == 32'sh8000_0000) h = 64'sd2147483647;
    else begin
      p = longint'(acc) * longint'(m);
      if (p >= 0) h = (p + two30) / two31;
      else        h = (p + 1 - two30) / two31;
    end
    if (sh == 0) r = h;
    else begin
      d = longint'(1) << sh;
      a = (h < 0) ? -h : h;
      q = (a + d / 2) / d;
      r = (h < 0) ? -q : q;
    end
    s = r + longint'(off);
    if (s < longint'(mn)) s = longint'(mn);
    if (s > longint'(mx)) s = longint'(mx);
    lo = -(longint'(1) << (OUT_W - 1));
    hi = (longint'(1) << (OUT_W - 1)) - 1;
    if (s < lo) s = lo;
    if (s > hi) s = hi;
    res = s[OUT_W-1:0];
    return res;
  endfunction

  function automatic logic [VW-1:0] model(beat_t b);
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++)
      v[OUT_W*i +: OUT_W] = ref_lane(int'(b.acc[32*i +: 32]), int'(b.mult), int'(b.shift),
                                     int'(b.off), int'(b.mn), int'(b.mx));
    return v;
  endfunction

  function automatic beat_t make_beat(int a, int m, int sh, int off, int mn, int mx);
    beat_t b;
    b.acc = {LANES{a}};
    b.mult = m;
    b.shift = 5'(sh);
    b.off = off;
    b.mn = mn;
    b.mx = mx;
    return b;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    int a, c, t;
    for (int i = 0; i < LANES; i++) begin
      case ($urandom_range(0, 3))
        0: b.acc[32*i +: 32] = $urandom;
        1: b.acc[32*i +: 32] = 32'($urandom_range(0, 131072)) - 32'd65536;
        2: b.acc[32*i +: 32] = 32'h8000_0000;
        default: b.acc[32*i +: 32] = 32'($urandom_range(0, 2000)) - 32'd1000;
      endcase
    end
    b.mult = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
    b.shift = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 12)) : 5'($urandom_range(0, 31));
    b.off = 32'($urandom_range(0, 255)) - 32'd128;
    a = int'($urandom_range(0, 400)) - 200;
    c = int'($urandom_range(0, 400)) - 200;
    if (a > c) begin t = a; a = c; c = t; end
    if ($urandom_range(0, 3) == 0) begin a = 32'sh8000_0000; c = 32'sh7FFF_FFFF; end
    b.mn = a;
    b.mx = c;
    return b;
  endfunction

  task automatic drive(input beat_t b);
    in_acc = b.acc;
    mult = b.mult;
    shift = b.shift;
    out_offset = b.off;
    act_min = b.mn;
    act_max = b.mx;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_data !== '0) begin n_errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_directed();
    int acc_v[4] = '{100, 32'sh8000_0000, -5, -3};
    int mult_v[4] = '{32'sh4000_0000, 32'sh8000_0000, 32'sh7FFF_FFFF, 32'sh4000_0000};
    int sh_v[4] = '{1, 24, 1, 0};
    int off_v[4] = '{-3, 0, 0, 0};
    logic [OUT_W-1:0] exp_v[4] = '{8'h16, 8'h7F, 8'hFD, 8'hFF};
    beat_t b;
    int lat;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      b = make_beat(acc_v[k], mult_v[k], sh_v[k], off_v[k], -128, 127);
      drive(b);
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 12) begin @(negedge clk); lat++; end
      n_checks++; if (lat != 4) begin n_errors++; $display("FAIL directed_latency[%0d]: got %0d cycles expected 4", k, lat); end
      n_checks++; if (out_data !== {LANES{exp_v[k]}}) begin n_errors++; $display("FAIL directed_value[%0d]: got %h expected %h", k, out_data, {LANES{exp_v[k]}}); end
      n_checks++; if (out_data !== model(b)) begin n_errors++; $display("FAIL directed_model[%0d]: got %h expected %h", k, out_data, model(b)); end
      @(negedge clk);
    end
  endtask

  task automatic test_stream_stall();
    beat_t bs[8];
    logic [VW-1:0] held, e;
    int sent = 0, got = 0, oc = -1, cyc = 0;
    bit stall;
    exp_q.delete();
    for (int i = 0; i < 8; i++) bs[i] = rand_beat();
    while (got < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (oc >= 0 || out_valid) oc++;
      stall = (oc >= 3 && oc <= 5);
      out_ready = !stall;
      in_valid = (sent < 8);
      if (sent < 8) drive(bs[sent]);
      #1;
      if (stall) begin
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL stall_in_ready[oc=%0d]: got %b expected 0", oc, in_ready); end
        if (oc == 3) held = out_data;
        else begin
          n_checks++; if (out_data !== held) begin n_errors++; $display("FAIL stall_stable[oc=%0d]: got %h expected %h", oc, out_data, held); end
        end
      end
      if (in_valid && in_ready) begin exp_q.push_back(model(bs[sent])); sent++; end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_errors++; $display("FAIL stream_extra: got %h expected no beat", out_data); end
        else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin n_errors++; $display("FAIL stream_data[%0d]: got %h expected %h", got, out_data, e); end
        end
        got++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (got != 8) begin n_errors++; $display("FAIL stream_count: got %0d expected 8", got); end
    repeat (6) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL stream_dup: got out_valid %b expected 0", out_valid); end
  endtask

  task automatic test_random();
    beat_t cur;
    logic [VW-1:0] e, prev_data;
    bit prev_hold = 0;
    int sent = 0, got = 0, cyc = 0;
    localparam int N = 200;
    exp_q.delete();
    cur = rand_beat();
    while (got < N && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (prev_hold) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          n_errors++; $display("FAIL random_hold: got %b/%h expected 1/%h", out_valid, out_data, prev_data);
        end
      end
      out_ready = ($urandom_range(0, 2) != 0);
      in_valid = (sent < N) && ($urandom_range(0, 3) != 0);
      drive(cur);
      #1;
      if (in_valid && in_ready) begin exp_q.push_back(model(cur)); sent++; cur = rand_beat(); end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_errors++; $display("FAIL random_extra: got %h expected no beat", out_data); end
        else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin n_errors++; $display("FAIL random_data[%0d]: got %h expected %h", got, out_data, e); end
        end
        got++;
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (got != N) begin n_errors++; $display("FAIL random_count: got %0d expected %0d", got, N); end
  endtask

  task automatic test_reset_inflight();
    int seen = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(rand_beat());
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL inflight_pre: got out_valid %b expected 1", out_valid); end
    #1 reset_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL async_reset_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_data !== '0) begin n_errors++; $display("FAIL async_reset_data: got %h expected 0", out_data); end
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (10) begin @(negedge clk); if (out_valid) seen++; end
    n_checks++; if (seen != 0) begin n_errors++; $display("FAIL reset_stale: got %0d beats expected 0", seen); end
  endtask

  task automatic test_flush();
    beat_t b;
    int seen = 0, lat;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      b = rand_beat();
      b.mn = -10;
      b.mx = 127;
      drive(b);
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_errors++; $display("FAIL flush_pre: got valid/ready %b/%b expected 1/0", out_valid, in_ready); end
    @(negedge clk);
    flush = 1'b1;
    in_valid = 1'b1;
    drive(rand_beat());
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
    out_ready = 1'b1;
    repeat (10) begin @(negedge clk); if (out_valid) seen++; end
    n_checks++; if (seen != 0) begin n_errors++; $display("FAIL flush_stale: got %0d beats expected 0", seen); end
    b = make_beat(-100, 32'sh4000_0000, 0, 0, -10, 127);
    drive(b);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin @(negedge clk); lat++; end
    n_checks++; if (lat != 4) begin n_errors++; $display("FAIL clamp_latency: got %0d cycles expected 4", lat); end
    n_checks++; if (out_data !== {LANES{8'hF6}}) begin n_errors++; $display("FAIL act_min_clamp: got %h expected %h", out_data, {LANES{8'hF6}}); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stream_stall();
    test_random();
    test_reset_inflight();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
